// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU datapath definitions: default register-file geometry and the
// register address / data types used by decode and writeback.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Default data width of a general-purpose register.
  localparam int DW_DEF    = 8;
  // Default number of general-purpose registers.
  localparam int DEPTH_DEF = 32;
  // Address width matching the default register count.
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One registered read port of the register file. Selects between the
// hardwired zero, the out-of-range zero, the same-cycle write bypass and the
// stored register value, then registers the result with a valid pulse.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_ni       in   1   asynchronous active-low reset
//   re_i         in   1   read enable
//   raddr_i      in   AW  read address
//   wr_ok_i      in   1   a write is being committed this cycle (not dropped)
//   waddr_i      in   AW  write address (for bypass compare)
//   wdata_i      in   DW  write data (bypass source)
//   mem_rdata_i  in   DW  stored value at raddr_i from the parent array
//   rdata_o      out  DW  registered read data
//   rvalid_o     out  1   read data valid pulse
// -----------------------------------------------------------------------------
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          wr_ok_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o
);

  // DEPTH widened by one bit so the range compare works even when DEPTH
  // equals 2**AW.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic          in_range_s;
  logic          zero_hit_s;
  logic          bypass_s;
  logic [DW-1:0] sel_s;
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;
  logic          rvalid_d;
  logic          rvalid_q;

  assign in_range_s = ({1'b0, raddr_i} < DEPTH_L);
  assign zero_hit_s = ZERO_REG && (raddr_i == {AW{1'b0}});
  // wr_ok_i already excludes dropped writes, so bypass never forwards them.
  assign bypass_s   = wr_ok_i && (waddr_i == raddr_i);

  // Read value selection in priority order: zero reg, out of range, bypass, array.
  always_comb begin
    sel_s = mem_rdata_i;
    if (zero_hit_s) begin
      sel_s = {DW{1'b0}};
    end else if (!in_range_s) begin
      sel_s = {DW{1'b0}};
    end else if (bypass_s) begin
      sel_s = wdata_i;
    end else begin
      sel_s = mem_rdata_i;
    end
  end

  // Next state of the output registers: load on enable, otherwise hold data.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (re_i) begin
      rdata_d  = sel_s;
      rvalid_d = 1'b1;
    end else begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
    end
  end

  // Output data and valid registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= {DW{1'b0}};
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule : regfile_rd_port

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// General-purpose register file: two registered read ports, one write port
// with write-to-read bypass, asynchronous clear, optional hardwired-zero R0
// and a per-register busy scoreboard set by issue (lock) and cleared by
// writeback (write). A lock and a write to the same register in one cycle
// leave it busy, since a newer producer has just issued.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   we         in   1   write enable
//   waddr      in   AW  write address
//   wdata      in   DW  write data
//   re_a/re_b          in   1   read enables
//   raddr_a/raddr_b    in   AW  read addresses
//   rdata_a/rdata_b    out  DW  registered read data
//   rvalid_a/rvalid_b  out  1   read valid pulses
//   lock       in   1   mark lock_addr busy
//   lock_addr  in   AW  register to mark busy
//   busy_a/busy_b      out  1   busy bit of raddr_a/raddr_b (combinational)
// -----------------------------------------------------------------------------
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  output logic          rvalid_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  output logic          rvalid_b,
  input  logic          lock,
  input  logic [AW-1:0] lock_addr,
  output logic          busy_a,
  output logic          busy_b
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // True when an address names a real, writable register (in range and not
  // the hardwired zero). Used for writes, locks and busy reporting alike.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !(ZERO_REG && (a == {AW{1'b0}}));
  endfunction

  logic [DW-1:0]    r_q [DEPTH];
  logic [DW-1:0]    r_d [DEPTH];
  logic [DEPTH-1:0] bsy_q;
  logic [DEPTH-1:0] bsy_d;

  logic             wr_ok_s;
  logic             lock_ok_s;
  logic [DW-1:0]    mem_a_s;
  logic [DW-1:0]    mem_b_s;

  assign wr_ok_s   = we   && addr_ok(waddr);
  assign lock_ok_s = lock && addr_ok(lock_addr);

  // Register array next state: only the committed write target changes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      r_d[i] = (wr_ok_s && (waddr == AW'(i))) ? wdata : r_q[i];
    end
  end

  // Scoreboard next state: lock has priority over the clearing write.
  always_comb begin
    bsy_d = bsy_q;
    for (int i = 0; i < DEPTH; i++) begin
      bsy_d[i] = (lock_ok_s && (lock_addr == AW'(i))) ? 1'b1 :
                 (wr_ok_s   && (waddr     == AW'(i))) ? 1'b0 : bsy_q[i];
    end
  end

  // Storage and scoreboard flops with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= {DW{1'b0}};
      end
      bsy_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= r_d[i];
      end
      bsy_q <= bsy_d;
    end
  end

  // Raw array reads; out-of-range and zero-register cases are masked in the
  // read ports and in the busy outputs below.
  assign mem_a_s = r_q[raddr_a];
  assign mem_b_s = r_q[raddr_b];

  assign busy_a = addr_ok(raddr_a) && bsy_q[raddr_a];
  assign busy_b = addr_ok(raddr_b) && bsy_q[raddr_b];

  regfile_rd_port #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_rd_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .re_i        (re_a),
    .raddr_i     (raddr_a),
    .wr_ok_i     (wr_ok_s),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .mem_rdata_i (mem_a_s),
    .rdata_o     (rdata_a),
    .rvalid_o    (rvalid_a)
  );

  regfile_rd_port #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_rd_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .re_i        (re_b),
    .raddr_i     (raddr_b),
    .wr_ok_i     (wr_ok_s),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .mem_rdata_i (mem_b_s),
    .rdata_o     (rdata_b),
    .rvalid_o    (rvalid_b)
  );

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
// Two register-file instances share one stimulus stream:
//   d0: DEPTH=32, ZERO_REG=0      d1: DEPTH=24, ZERO_REG=1
// Expected values come from a simple array model of the register file.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic       re_a;
  logic [4:0] raddr_a;
  logic       re_b;
  logic [4:0] raddr_b;
  logic       lock;
  logic [4:0] lock_addr;

  logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic       rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
  logic       busy_a0, busy_b0, busy_a1, busy_b1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index [instance][register].
  logic [7:0] mdl_mem [2][32];
  bit         mdl_bsy [2][32];
  logic [7:0] exp_rd_a [2];
  logic [7:0] exp_rd_b [2];
  bit         exp_v_a  [2];
  bit         exp_v_b  [2];

  always #5 clk = ~clk;

  regfile_2r1w #(.DW(8), .DEPTH(32), .ZERO_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .lock(lock), .lock_addr(lock_addr), .busy_a(busy_a0), .busy_b(busy_b0)
  );

  regfile_2r1w #(.DW(8), .DEPTH(24), .ZERO_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
    .lock(lock), .lock_addr(lock_addr), .busy_a(busy_a1), .busy_b(busy_b1)
  );

  function automatic int depth_of(int k);
    return (k == 0) ? 32 : 24;
  endfunction

  // A register that can hold data and be locked.
  function automatic bit addr_valid(int k, int a);
    return (a < depth_of(k)) && !((k == 1) && (a == 0));
  endfunction

  function automatic logic [7:0] mdl_read(int k, int a);
    if (!addr_valid(k, a)) return 8'h00;
    if (we && addr_valid(k, int'(waddr)) && (int'(waddr) == a)) return wdata;
    return mdl_mem[k][a];
  endfunction

  function automatic logic mdl_busy(int k, int a);
    if (!addr_valid(k, a)) return 1'b0;
    return mdl_bsy[k][a];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " d0 rdata_a"},  rdata_a0,          exp_rd_a[0]);
    chk({tag, " d0 rdata_b"},  rdata_b0,          exp_rd_b[0]);
    chk({tag, " d0 rvalid_a"}, {7'd0, rvalid_a0}, {7'd0, exp_v_a[0]});
    chk({tag, " d0 rvalid_b"}, {7'd0, rvalid_b0}, {7'd0, exp_v_b[0]});
    chk({tag, " d0 busy_a"},   {7'd0, busy_a0},   {7'd0, mdl_busy(0, int'(raddr_a))});
    chk({tag, " d0 busy_b"},   {7'd0, busy_b0},   {7'd0, mdl_busy(0, int'(raddr_b))});
    chk({tag, " d1 rdata_a"},  rdata_a1,          exp_rd_a[1]);
    chk({tag, " d1 rdata_b"},  rdata_b1,          exp_rd_b[1]);
    chk({tag, " d1 rvalid_a"}, {7'd0, rvalid_a1}, {7'd0, exp_v_a[1]});
    chk({tag, " d1 rvalid_b"}, {7'd0, rvalid_b1}, {7'd0, exp_v_b[1]});
    chk({tag, " d1 busy_a"},   {7'd0, busy_a1},   {7'd0, mdl_busy(1, int'(raddr_a))});
    chk({tag, " d1 busy_b"},   {7'd0, busy_b1},   {7'd0, mdl_busy(1, int'(raddr_b))});
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 32; a++) begin
        mdl_mem[k][a] = 8'h00;
        mdl_bsy[k][a] = 1'b0;
      end
      exp_rd_a[k] = 8'h00;
      exp_rd_b[k] = 8'h00;
      exp_v_a[k]  = 1'b0;
      exp_v_b[k]  = 1'b0;
    end
  endtask

  task automatic set_idle();
    we = 1'b0; waddr = 5'd0; wdata = 8'h00;
    re_a = 1'b0; raddr_a = 5'd0;
    re_b = 1'b0; raddr_b = 5'd0;
    lock = 1'b0; lock_addr = 5'd0;
  endtask

  // Predict one clock edge from the current inputs, run it, then compare.
  task automatic apply(input string tag);
    for (int k = 0; k < 2; k++) begin
      if (re_a) exp_rd_a[k] = mdl_read(k, int'(raddr_a));
      if (re_b) exp_rd_b[k] = mdl_read(k, int'(raddr_b));
      exp_v_a[k] = re_a;
      exp_v_b[k] = re_b;
    end
    for (int k = 0; k < 2; k++) begin
      if (we && addr_valid(k, int'(waddr))) begin
        mdl_mem[k][int'(waddr)] = wdata;
        mdl_bsy[k][int'(waddr)] = 1'b0;
      end
      if (lock && addr_valid(k, int'(lock_addr))) mdl_bsy[k][int'(lock_addr)] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    clear_model();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Read R5 after reset.
    set_idle(); re_a = 1'b1; raddr_a = 5'd5;
    apply("rd_r5");
    chk("rd_r5 const", rdata_a0, 8'h00);

    // Write R3, then read it on both ports.
    set_idle(); we = 1'b1; waddr = 5'd3; wdata = 8'hA5;
    apply("wr_r3");
    set_idle(); re_a = 1'b1; raddr_a = 5'd3; re_b = 1'b1; raddr_b = 5'd3;
    apply("rd_r3");
    chk("rd_r3 const a", rdata_a0, 8'hA5);
    chk("rd_r3 const b", rdata_b1, 8'hA5);

    // Same-cycle write and read of R7 (bypass).
    set_idle(); we = 1'b1; waddr = 5'd7; wdata = 8'h3C; re_a = 1'b1; raddr_a = 5'd7;
    apply("byp_r7");
    chk("byp_r7 const", rdata_a1, 8'h3C);

    // Write R0: kept without zero register, dropped with it.
    set_idle(); we = 1'b1; waddr = 5'd0; wdata = 8'hFF;
    apply("wr_r0");
    set_idle(); re_a = 1'b1; raddr_a = 5'd0;
    apply("rd_r0");
    chk("rd_r0 d0 const", rdata_a0, 8'hFF);
    chk("rd_r0 d1 const", rdata_a1, 8'h00);

    // Out-of-range write on the 24-entry instance.
    set_idle(); we = 1'b1; waddr = 5'd14; wdata = 8'h5A;
    apply("wr_r14");
    set_idle(); we = 1'b1; waddr = 5'd30; wdata = 8'h11;
    apply("wr_r30");
    set_idle(); re_a = 1'b1; raddr_a = 5'd30; re_b = 1'b1; raddr_b = 5'd14;
    apply("rd_r30_r14");
    chk("rd_r30 d1 const", rdata_a1, 8'h00);
    chk("rd_r14 d1 const", rdata_b1, 8'h5A);
    chk("rd_r30 d0 const", rdata_a0, 8'h11);

    // Scoreboard sequence on R9.
    set_idle(); lock = 1'b1; lock_addr = 5'd9; raddr_a = 5'd9;
    apply("lock_r9");
    chk("lock_r9 const", {7'd0, busy_a1}, 8'h01);
    set_idle(); lock = 1'b1; lock_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 8'h99; raddr_a = 5'd9;
    apply("lock_wr_r9");
    chk("lock_wr_r9 const", {7'd0, busy_a0}, 8'h01);
    set_idle(); we = 1'b1; waddr = 5'd9; wdata = 8'h42; raddr_a = 5'd9;
    apply("wr_r9");
    chk("wr_r9 const", {7'd0, busy_a0}, 8'h00);
    set_idle(); lock = 1'b1; lock_addr = 5'd9; raddr_a = 5'd9; re_b = 1'b1; raddr_b = 5'd9;
    apply("relock_r9");
    // Ignored locks: R0 and out-of-range on the zero-register instance.
    set_idle(); lock = 1'b1; lock_addr = 5'd0; raddr_a = 5'd0; raddr_b = 5'd9;
    apply("lock_r0");
    set_idle(); lock = 1'b1; lock_addr = 5'd28; raddr_a = 5'd28; raddr_b = 5'd9;
    apply("lock_r28");

    // Asynchronous reset in the middle of the sequence.
    raddr_a = 5'd9; lock = 1'b0;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_all("mid_reset");
    chk("mid_reset busy const", {7'd0, busy_a1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle(); re_a = 1'b1; raddr_a = 5'd9; re_b = 1'b1; raddr_b = 5'd3;
    apply("post_reset_rd");

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      we        = ($urandom_range(1, 0) == 1);
      waddr     = 5'($urandom_range(31, 0));
      wdata     = 8'($urandom_range(255, 0));
      re_a      = ($urandom_range(3, 0) != 0);
      raddr_a   = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom_range(31, 0));
      re_b      = ($urandom_range(3, 0) != 0);
      raddr_b   = ($urandom_range(3, 0) == 0) ? raddr_a : 5'($urandom_range(31, 0));
      lock      = ($urandom_range(3, 0) == 0);
      lock_addr = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom_range(31, 0));
      apply("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_2r1w

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised general-purpose register file for the RISC CPU datapath, successor to the single-port 8-bit register store. Provides two independent registered read ports and one write port with write-to-read bypass, full asynchronous clear, an optional hardwired-zero register 0, and a per-register busy scoreboard. The decode stage drives both read ports, and the writeback stage drives the write port.

## Interface
- `DW`, 8, data width in bits
- `DEPTH`, 32, number of registers; need not be a power of two
- `AW`, `$clog2(DEPTH)`, address width; the full address is used with no truncation
- `ZERO_REG`, 0, if 1 then R0 always reads 0 and writes to it are dropped

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `we`  in  1  write enable
- `waddr`  in  AW  write address
- `wdata`  in  DW  write data
- `re_a`  in  1  read port A enable
- `raddr_a`  in  AW  read port A address
- `rdata_a`  out  DW  port A read data, registered
- `rvalid_a`  out  1  port A data valid pulse
- `re_b`, `raddr_b`, `rdata_b`, `rvalid_b`: port B, identical to port A
- `lock`  in  1  mark `lock_addr` busy (instruction issued with this destination)
- `lock_addr`  in  AW  register to mark busy
- `busy_a`  out  1  busy bit of `raddr_a`, combinational
- `busy_b`  out  1  busy bit of `raddr_b`, combinational

## Operation
- Storage: DEPTH × DW flops `R[]` plus DEPTH busy flops `bsy[]`.
- Write: on a rising edge with `we=1` and `waddr<DEPTH`, `R[waddr]<=wdata` and `bsy[waddr]<=0`.
- Dropped writes: a write is ignored if `waddr>=DEPTH`, or if `ZERO_REG=1` and `waddr=0`.
- Read: on a rising edge with `re_x=1`, `rdata_x` is loaded with the selected value and `rvalid_x<=1`. With `re_x=0`, `rdata_x` holds its previous value and `rvalid_x<=0`.
- Read value selection, in priority order:
  1. `ZERO_REG=1` and address 0: returns 0.
  2. Address `>=DEPTH`: returns 0.
  3. `we=1` and `waddr==raddr_x` in the same cycle, and the write is not dropped: returns `wdata` (bypass).
  4. Otherwise: returns `R[raddr_x]`.
- Both ports may read the same address in the same cycle; both return the same value.
- Lock: on a rising edge with `lock=1` and `lock_addr<DEPTH`, `bsy[lock_addr]<=1`.
  - Lock of R0 when `ZERO_REG=1` is ignored.
  - Lock of an address `>=DEPTH` is ignored.
- Lock and write to the same address in the same cycle: lock wins and `bsy` ends at 1 (a new producer has issued). `R` is still updated.
- `busy_x = bsy[raddr_x]`, and reads 0 for an out-of-range address or for R0 when `ZERO_REG=1`. It does not reflect a same-cycle write.

## Timing
- Reset (`rst_n=0`, asynchronous): all `R` cleared to 0, all `bsy` cleared to 0, `rdata_a=rdata_b=0`, `rvalid_a=rvalid_b=0`. Any write or lock in flight during reset is lost.
- Read latency: one cycle. The address is sampled at edge N, and `rdata`/`rvalid` are valid after edge N.
- Write-to-read: a read issued in the same cycle as the write returns the new data via bypass. There is no extra stall cycle.
- Busy: `busy_x` updates combinationally from `raddr_x`. A lock at edge N is visible from edge N onwards, and a write at edge N clears busy from edge N onwards.
- Reset release: synchronous to `clk`, handled by the top-level reset synchroniser. No reset logic inside this block beyond the asynchronous clear.

## Structure
- Shared package `cpu_pkg`: default `DW`, `DEPTH`, and the `reg_addr_t` typedef. The ZERO_REG default constant is owned by CPU top-level configuration.
- Sub-module `regfile_rd_port`, instantiated twice. It contains the out-of-range, zero and bypass selection mux and the `rdata`/`rvalid` registers. Storage, write logic and scoreboard stay in the parent.

## Test plan
- Reset, then read R5 on port A → `rdata_a=0`, `rvalid_a=1` one cycle later. Also check `busy_a=0`.
- Write R3=`8'hA5`, then read R3 on A and B the next cycle → both ports return `8'hA5`.
- In the same cycle, write R7=`8'h3C` and read R7 on port A → `rdata_a=8'h3C` after that edge (bypass).
- Write R0=`8'hFF` with `ZERO_REG=1` → read of R0 returns 0. With `ZERO_REG=0` the same sequence returns `8'hFF`.
- With `DEPTH=24`, write address 30=`8'h11` → ignored. A read of address 30 returns 0, and a read of address 14 (30 mod 16) is unchanged.
- Scoreboard sequence:
  1. Lock R9 → `busy_a=1` with `raddr_a=9`.
  2. Lock and write R9 in the same cycle → busy stays 1.
  3. Write R9 alone → `busy_a=0`.
  4. Assert `rst_n=0` mid-sequence → all busy bits and data return to 0 immediately.
